keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad (PmodKYPD-style: active-low column drives, active-low row senses with pull-ups).
- Debounces the scan result and decodes the pressed key into a 4-bit hex code.
- Acts as the writer for the keypad driver's 4-bit holding register: `key_code` feeds the register DIN and `key_ld` drives its LD for exactly one clock per accepted press.

Parameters:
- SCAN_DIV, 100000, clock cycles each column is driven (1 ms at 100 MHz); minimum 4.
- DEBOUNCE_SCANS, 4, consecutive identical full-frame results needed to accept a press or a release; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- row  input  4  keypad row senses, active-low; row[0] is the top row. Asynchronous to clk.
- col  output  4  keypad column drives, active-low, one-hot-low; col[0] is the leftmost column.
- key_code  output  4  hex code of the last accepted key; held until the next accepted key.
- key_ld  output  1  one-cycle pulse, coincident with the cycle `key_code` updates.
- key_valid  output  1  high while an accepted key is considered held.

Behaviour:
- Reset (async assert, sync deassert use): col=4'b1110, key_code=4'h0, key_ld=0, key_valid=0, all counters 0, synchronizer flops 4'hF, frame accumulator cleared.
- Row synchronizer: 2-flop, all 4 bits; downstream logic uses only the synchronized value.
- Column FSM, states S_SCAN and S_EVAL:
  - S_SCAN: dwell counter counts 0..SCAN_DIV-1 with column index c driven (col = ~(1<<c)).
  - At dwell==SCAN_DIV-1: sample the synchronized row into the frame accumulator for column c, advance c (3 wraps to 0), reset dwell.
  - After sampling column 3: go to S_EVAL for one cycle; col already shows column 0.
  - S_EVAL returns to S_SCAN.
  - Frame length: 4*SCAN_DIV+1 cycles.
- Frame result (S_EVAL):
  - Exactly one of the 16 sensed bits low: KEY(code).
  - Zero bits low: NONE.
  - Two or more bits low: NONE (multi-press ignored).
- Key map, (row r, col c) -> code:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: 0,F,E,D
- Debounce (S_EVAL only):
  - If result equals the previous frame's result: stable_cnt increments, saturating at DEBOUNCE_SCANS.
  - Otherwise: stable_cnt=1 and the stored result is updated.
- Accept press:
  - Condition: stable_cnt reaches DEBOUNCE_SCANS on a frame with KEY(k), and (key_valid==0 or k != key_code).
  - Action: next cycle key_code=k, key_ld=1 for exactly one cycle, key_valid=1.
  - A different stable key while one is held issues a new pulse. The same key held indefinitely issues no further pulses.
- Accept release:
  - Condition: stable_cnt reaches DEBOUNCE_SCANS on a frame with NONE.
  - Action: key_valid=0, key_code unchanged, no key_ld.
- Latency: press stable at the pins to key_ld is at most (DEBOUNCE_SCANS+1)*(4*SCAN_DIV+1)+3 cycles.
- key_ld is never high in two consecutive cycles and never asserts outside the cycle after an S_EVAL.
- Reset mid-frame or mid-press: everything returns to reset values. A key still held after reset is re-accepted as a fresh press (new pulse).

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3; frame=17 cycles):
- Reset, row=4'hF: col=1110, key_code=0, key_ld=0, key_valid=0. After release, col steps 1110->1101->1011->0111 every 4 cycles, then back to 1110 at frame start. No key_ld for 10 frames.
- Model key '5' (row[1] low whenever col[1] low), held 10 frames: exactly one key_ld pulse with key_code=4'h5 and key_valid=1, within 71 cycles of press start. No further pulses while held.
- Key '5' present in frames 1 and 3 only, then stable from frame 4: no pulse before 3 consecutive stable frames; then exactly one pulse with code 4'h5.
- Release '5': key_valid falls after 3 NONE frames; key_code stays 4'h5; no key_ld. Then press 'E' (r3, c2): one pulse with key_code=4'hE.
- Keys '1' and 'A' pressed together for 10 frames: no key_ld, key_valid stays 0. Release 'A' leaving '1': one pulse with key_code=4'h1.
- Hold 'D' until accepted, assert rst_n low mid-frame for 3 cycles: outputs immediately 0 and col=1110. After release with 'D' still held: one new pulse with key_code=4'hD.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sync, per-frame decode, debounce, hex key output.
// Latency: a press stable at the pins reaches key_ld within (DEBOUNCE_SCANS+1) frames plus 3 cycles.
// Backpressure: none; key_ld is a one-cycle load strobe for an always-ready holding register.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_ld,
    output logic       key_valid
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_SCANS);

    typedef enum logic {S_SCAN, S_EVAL} state_t;

    state_t          state, state_nxt;
    logic [3:0]      row_s1, row_s2;
    logic [DW-1:0]   dwell, dwell_nxt;
    logic [1:0]      col_idx, col_idx_nxt;
    logic [15:0]     frame, frame_nxt;
    logic [4:0]      prev_res, prev_res_nxt;
    logic [CW-1:0]   stable_cnt, stable_cnt_nxt, cnt_step;
    logic [3:0]      key_code_nxt;
    logic            key_ld_nxt, key_valid_nxt;

    logic [15:0]     low;
    logic            single;
    logic [3:0]      hit_idx;
    logic [4:0]      cur_res;
    logic            stable_hit;

    // Frame bit index is {column, row}
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'h0: code = 4'h1;  4'h1: code = 4'h4;  4'h2: code = 4'h7;  4'h3: code = 4'h0;
            4'h4: code = 4'h2;  4'h5: code = 4'h5;  4'h6: code = 4'h8;  4'h7: code = 4'hF;
            4'h8: code = 4'h3;  4'h9: code = 4'h6;  4'hA: code = 4'h9;  4'hB: code = 4'hE;
            4'hC: code = 4'hA;  4'hD: code = 4'hB;  4'hE: code = 4'hC;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign col = ~(4'b0001 << col_idx);

    always_comb begin
        low     = ~frame;
        single  = (low != 16'h0000) && ((low & (low - 16'd1)) == 16'h0000);
        hit_idx = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (low[i]) hit_idx = 4'(i);
        end
        // NONE is encoded as all zeros, so multi-press and idle compare equal
        cur_res    = single ? {1'b1, key_map(hit_idx)} : 5'b0_0000;
        cnt_step   = (cur_res != prev_res) ? CW'(1) :
                     (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + CW'(1);
        stable_hit = (cnt_step == CNT_MAX);
    end

    always_comb begin
        state_nxt      = state;
        dwell_nxt      = dwell;
        col_idx_nxt    = col_idx;
        frame_nxt      = frame;
        prev_res_nxt   = prev_res;
        stable_cnt_nxt = stable_cnt;
        key_code_nxt   = key_code;
        key_ld_nxt     = 1'b0;
        key_valid_nxt  = key_valid;
        case (state)
            S_SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_nxt                         = '0;
                    frame_nxt[{col_idx, 2'b00} +: 4]  = row_s2;
                    col_idx_nxt                       = col_idx + 2'd1;
                    if (col_idx == 2'd3) state_nxt = S_EVAL;
                end else begin
                    dwell_nxt = dwell + DW'(1);
                end
            end
            S_EVAL: begin
                state_nxt      = S_SCAN;
                prev_res_nxt   = cur_res;
                stable_cnt_nxt = cnt_step;
                if (stable_hit && cur_res[4]) begin
                    if (!key_valid || (cur_res[3:0] != key_code)) begin
                        key_code_nxt  = cur_res[3:0];
                        key_ld_nxt    = 1'b1;
                        key_valid_nxt = 1'b1;
                    end
                end else if (stable_hit) begin
                    key_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = S_SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1     <= 4'hF;
            row_s2     <= 4'hF;
            state      <= S_SCAN;
            dwell      <= '0;
            col_idx    <= 2'd0;
            frame      <= 16'hFFFF;
            prev_res   <= 5'b0_0000;
            stable_cnt <= '0;
            key_code   <= 4'h0;
            key_ld     <= 1'b0;
            key_valid  <= 1'b0;
        end else begin
            row_s1     <= row;
            row_s2     <= row_s1;
            state      <= state_nxt;
            dwell      <= dwell_nxt;
            col_idx    <= col_idx_nxt;
            frame      <= frame_nxt;
            prev_res   <= prev_res_nxt;
            stable_cnt <= stable_cnt_nxt;
            key_code   <= key_code_nxt;
            key_ld     <= key_ld_nxt;
            key_valid  <= key_valid_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix (SCAN_DIV=4, DEBOUNCE_SCANS=3).
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam int FR = 4 * SD + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_ld;
    logic       key_valid;

    logic [15:0] keys = 16'h0000;   // bit r*4+c = key at row r, column c pressed

    int n_cmp = 0;
    int n_err = 0;
    int ld_cnt = 0;
    int ld_cyc = 0;
    int cyc = 0;
    logic ld_prev = 1'b0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_ld    (key_ld),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (key_ld) begin
            ld_cnt = ld_cnt + 1;
            ld_cyc = cyc;
            n_cmp  = n_cmp + 1;
            assert (ld_prev === 1'b0) else begin
                n_err = n_err + 1;
                $error("FAIL ld_back_to_back obs=1 exp=0");
            end
        end
        ld_prev = key_ld;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Returns in the evaluate cycle: col has just wrapped from column 3 to column 0
    task automatic wait_eval(input string tag);
        logic [3:0] p;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * FR && !found; i++) begin
            p = col;
            tick();
            if (p == 4'b0111 && col == 4'b1110) found = 1'b1;
        end
        if (!found) check(tag, 16'd0, 16'd1);
    endtask

    task automatic wait_ld(input string tag, input int base, input int budget);
        int i;
        i = 0;
        while (ld_cnt <= base && i < budget) begin
            tick();
            i++;
        end
        if (ld_cnt <= base) check(tag, 16'd0, 16'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t0;
        logic [3:0] exp_col;

        ticks(2);
        check("rst_col", 16'(col), 16'hE);
        check("rst_code", 16'(key_code), 16'h0);
        check("rst_ld", 16'(key_ld), 16'h0);
        check("rst_valid", 16'(key_valid), 16'h0);

        rst_n = 1'b1;
        for (int p = 1; p <= FR; p++) begin
            tick();
            exp_col = (p < 4) ? 4'b1110 : (p < 8) ? 4'b1101 :
                      (p < 12) ? 4'b1011 : (p < 16) ? 4'b0111 : 4'b1110;
            check($sformatf("col_step_%0d", p), 16'(col), 16'(exp_col));
        end
        base = ld_cnt;
        ticks(10 * FR);
        check("idle_no_ld", 16'(ld_cnt - base), 16'd0);

        // Key '5' pressed at an arbitrary point in the frame
        ticks(5);
        base = ld_cnt;
        t0 = cyc;
        keys = 16'h0020;
        wait_ld("press5_timeout", base, 100);
        check("press5_latency_ok", 16'((ld_cyc - t0) <= 71), 16'd1);
        check("press5_ld", 16'(key_ld), 16'd1);
        check("press5_code", 16'(key_code), 16'h5);
        check("press5_valid", 16'(key_valid), 16'd1);
        ticks(9 * FR);
        check("press5_single", 16'(ld_cnt - base), 16'd1);
        check("press5_held_valid", 16'(key_valid), 16'd1);

        // Release '5' on a frame boundary
        wait_eval("rel_align");
        keys = 16'h0000;
        base = ld_cnt;
        wait_eval("rel_e1");
        wait_eval("rel_e2");
        tick();
        check("rel_valid_after2", 16'(key_valid), 16'd1);
        wait_eval("rel_e3");
        tick();
        check("rel_valid_after3", 16'(key_valid), 16'd0);
        check("rel_code_kept", 16'(key_code), 16'h5);
        check("rel_no_ld", 16'(ld_cnt - base), 16'd0);

        // Bouncy '5': frames 1 and 3, then stable from frame 4
        wait_eval("bnc_align");
        keys = 16'h0020;
        base = ld_cnt;
        wait_eval("bnc_e1");
        keys = 16'h0000;
        wait_eval("bnc_e2");
        keys = 16'h0020;
        wait_eval("bnc_e3");
        wait_eval("bnc_e4");
        tick();
        check("bnc_no_early_ld", 16'(ld_cnt - base), 16'd0);
        check("bnc_no_early_valid", 16'(key_valid), 16'd0);
        wait_eval("bnc_e5");
        tick();
        check("bnc_ld", 16'(key_ld), 16'd1);
        check("bnc_code", 16'(key_code), 16'h5);
        check("bnc_single", 16'(ld_cnt - base), 16'd1);

        // Release, then 'E' at row 3 column 2
        keys = 16'h0000;
        ticks(5 * FR);
        check("relE_valid", 16'(key_valid), 16'd0);
        check("relE_code", 16'(key_code), 16'h5);
        base = ld_cnt;
        keys = 16'h4000;
        wait_ld("pressE_timeout", base, 100);
        check("pressE_code", 16'(key_code), 16'hE);
        check("pressE_ld", 16'(key_ld), 16'd1);
        ticks(4 * FR);
        check("pressE_single", 16'(ld_cnt - base), 16'd1);

        // '1' and 'A' together are ignored; dropping 'A' accepts '1'
        keys = 16'h0000;
        ticks(5 * FR);
        base = ld_cnt;
        keys = 16'h0009;
        ticks(10 * FR);
        check("multi_no_ld", 16'(ld_cnt - base), 16'd0);
        check("multi_valid", 16'(key_valid), 16'd0);
        keys = 16'h0001;
        wait_ld("one_timeout", base, 100);
        check("one_code", 16'(key_code), 16'h1);
        check("one_valid", 16'(key_valid), 16'd1);
        ticks(3 * FR);
        check("one_single", 16'(ld_cnt - base), 16'd1);

        // Hold 'D', reset mid-frame, expect re-acceptance
        keys = 16'h8000;
        base = ld_cnt;
        wait_ld("d_timeout", base, 100);
        check("d_code", 16'(key_code), 16'hD);
        ticks(7);
        rst_n = 1'b0;
        #1;
        check("rstmid_code", 16'(key_code), 16'h0);
        check("rstmid_valid", 16'(key_valid), 16'd0);
        check("rstmid_ld", 16'(key_ld), 16'd0);
        check("rstmid_col", 16'(col), 16'hE);
        ticks(3);
        rst_n = 1'b1;
        base = ld_cnt;
        wait_ld("d_again_timeout", base, 100);
        check("d_again_code", 16'(key_code), 16'hD);
        check("d_again_valid", 16'(key_valid), 16'd1);
        ticks(5 * FR);
        check("d_again_single", 16'(ld_cnt - base), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
